vbfs_apply: RTL and testbench

Apply stage of the vertex-centric BFS pipeline, the outbound counterpart of the gather stage. It reads per-node state from the state memory, and for every node marked active for the current level it emits one BFS message carrying the node's id as sender. It also writes the node back with the active flag cleared. Barrier tokens travel in order through the same two-entry output queue, so a barrier never overtakes the messages of its level.

---
 rtl/vbfs_apply.sv | 126 ++++++++++++
 tb/tb_vbfs_apply.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vbfs_apply.sv
// vbfs_apply: apply stage of the vertex-centric BFS pipeline.
// Emits one message per active node (sender = node id, level = level + 1),
// writes the node back with its active flag cleared, and forwards barrier
// tokens in order through a two-entry output queue.
// Optional feature macro: VBFS_APPLY_STATS_EN (enables the stat_sent counter).
module vbfs_apply (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] level_in,
    input  logic [31:0] nodeid_in,
    input  logic [31:0] state_in_parent,
    input  logic        state_in_active,
    input  logic        barrier_in,
    input  logic        valid_in,
    output logic        ready,
    output logic [31:0] nodeid_out,
    output logic [31:0] state_out_parent,
    output logic        state_out_active,
    output logic        state_wr_valid,
    output logic [31:0] message_out_sender,
    output logic [31:0] message_out_level,
    output logic        message_barrier,
    output logic        message_valid,
    input  logic        message_ack,
    output logic [31:0] stat_sent
);

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    logic [CW-1:0] count;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [W-1:0]  fifo_sender  [DEPTH];
    logic [W-1:0]  fifo_level   [DEPTH];
    logic          fifo_barrier [DEPTH];

    logic accept;
    logic enq;
    logic deq;
    logic node_wb;

    // Handshake decode; ready depends only on the registered occupancy, so a
    // dequeue never frees a slot for an enqueue in the same cycle.
    assign ready         = (count < CW'(DEPTH));
    assign accept        = valid_in && ready;
    assign node_wb       = accept && !barrier_in && state_in_active;
    assign enq           = accept && (barrier_in || state_in_active);
    assign message_valid = (count != '0);
    assign deq           = message_valid && message_ack;

    // Head entry drives the message outputs; zeros while the queue is empty.
    assign message_out_sender = message_valid ? fifo_sender[rd_ptr]  : '0;
    assign message_out_level  = message_valid ? fifo_level[rd_ptr]   : '0;
    assign message_barrier    = message_valid ? fifo_barrier[rd_ptr] : 1'b0;

    // Writeback always clears the active flag.
    assign state_out_active = 1'b0;

    // Output queue storage, pointers and occupancy.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_sender[i]  <= '0;
                fifo_level[i]   <= '0;
                fifo_barrier[i] <= 1'b0;
            end
        end else begin
            if (enq) begin
                fifo_sender[wr_ptr]  <= barrier_in ? '0 : nodeid_in;
                fifo_level[wr_ptr]   <= barrier_in ? level_in : level_in + W'(1);
                fifo_barrier[wr_ptr] <= barrier_in;
                wr_ptr               <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered writeback strobe, one cycle after an active node is accepted.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_wr_valid   <= 1'b0;
            nodeid_out       <= '0;
            state_out_parent <= '0;
        end else begin
            state_wr_valid <= node_wb;
            if (node_wb) begin
                nodeid_out       <= nodeid_in;
                state_out_parent <= state_in_parent;
            end
        end
    end

`ifdef VBFS_APPLY_STATS_EN
    logic [W-1:0] sent_cnt;

    // Messages sent since the last barrier, saturating; cleared when a barrier leaves.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sent_cnt <= '0;
        end else if (deq) begin
            if (fifo_barrier[rd_ptr]) begin
                sent_cnt <= '0;
            end else if (sent_cnt != '1) begin
                sent_cnt <= sent_cnt + W'(1);
            end
        end
    end

    assign stat_sent = sent_cnt;
`else
    assign stat_sent = '0;
`endif

endmodule

// File: tb/tb_vbfs_apply.sv
// Testbench for vbfs_apply: table-driven directed vectors plus hand-written
// sequences for stalls with ordering, and reset flushing a full queue.
module tb_vbfs_apply;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] level_in;
    logic [31:0] nodeid_in;
    logic [31:0] state_in_parent;
    logic        state_in_active;
    logic        barrier_in;
    logic        valid_in;
    logic        ready;
    logic [31:0] nodeid_out;
    logic [31:0] state_out_parent;
    logic        state_out_active;
    logic        state_wr_valid;
    logic [31:0] message_out_sender;
    logic [31:0] message_out_level;
    logic        message_barrier;
    logic        message_valid;
    logic        message_ack;
    logic [31:0] stat_sent;

    int errors = 0;
    int checks = 0;

    vbfs_apply dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .level_in           (level_in),
        .nodeid_in          (nodeid_in),
        .state_in_parent    (state_in_parent),
        .state_in_active    (state_in_active),
        .barrier_in         (barrier_in),
        .valid_in           (valid_in),
        .ready              (ready),
        .nodeid_out         (nodeid_out),
        .state_out_parent   (state_out_parent),
        .state_out_active   (state_out_active),
        .state_wr_valid     (state_wr_valid),
        .message_out_sender (message_out_sender),
        .message_out_level  (message_out_level),
        .message_barrier    (message_barrier),
        .message_valid      (message_valid),
        .message_ack        (message_ack),
        .stat_sent          (stat_sent)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        v;
        logic        b;
        logic        a;
        logic [31:0] nid;
        logic [31:0] par;
        logic [31:0] lvl;
        logic        ack;
        logic        e_rdy;
        logic        e_mv;
        logic [31:0] e_snd;
        logic [31:0] e_lvl;
        logic        e_bar;
        logic        e_wr;
        logic [31:0] e_nid;
        logic [31:0] e_par;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic b, input logic a,
                                input logic [31:0] nid, input logic [31:0] par,
                                input logic [31:0] lvl, input logic ack,
                                input logic e_rdy, input logic e_mv,
                                input logic [31:0] e_snd, input logic [31:0] e_lvl,
                                input logic e_bar, input logic e_wr,
                                input logic [31:0] e_nid, input logic [31:0] e_par);
        vec_t r;
        r.v = v; r.b = b; r.a = a; r.nid = nid; r.par = par; r.lvl = lvl; r.ack = ack;
        r.e_rdy = e_rdy; r.e_mv = e_mv; r.e_snd = e_snd; r.e_lvl = e_lvl;
        r.e_bar = e_bar; r.e_wr = e_wr; r.e_nid = e_nid; r.e_par = e_par;
        return r;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_in        = 1'b0;
        barrier_in      = 1'b0;
        state_in_active = 1'b0;
        nodeid_in       = 32'd0;
        state_in_parent = 32'd0;
        level_in        = 32'd0;
    endtask

    initial begin
        logic [31:0] seq_nid [3];
        logic [31:0] exp_snd [3];
        logic [31:0] exp_lvl [3];
        logic        exp_bar [3];
        logic [31:0] prev_snd;
        logic [31:0] prev_lvl;
        logic        prev_bar;
        logic        stalled;
        logic        barrier_left;
        int          idx;
        int          popped;
        int          cyc;

        // Rows: inputs, then outputs expected just after the clock edge.
        //              v  b  a  nid  par  lvl            ack  rdy mv snd lvl bar wr nid par
        vecs[0]  = mk(1, 0, 1, 5,   3,   2,             1,   1,  1, 5,  3,  0,  1, 5,  3);
        vecs[1]  = mk(0, 0, 0, 0,   0,   0,             1,   1,  0, 0,  0,  0,  0, 0,  0);
        vecs[2]  = mk(1, 0, 0, 7,   0,   2,             1,   1,  0, 0,  0,  0,  0, 0,  0);
        vecs[3]  = mk(0, 0, 0, 0,   0,   0,             1,   1,  0, 0,  0,  0,  0, 0,  0);
        vecs[4]  = mk(0, 0, 0, 0,   0,   0,             1,   1,  0, 0,  0,  0,  0, 0,  0);
        vecs[5]  = mk(0, 0, 0, 0,   0,   0,             1,   1,  0, 0,  0,  0,  0, 0,  0);
        vecs[6]  = mk(1, 0, 1, 1,   9,   4,             0,   1,  1, 1,  5,  0,  1, 1,  9);
        vecs[7]  = mk(1, 0, 1, 2,   10,  4,             0,   0,  1, 1,  5,  0,  1, 2,  10);
        vecs[8]  = mk(1, 0, 1, 3,   12,  4,             0,   0,  1, 1,  5,  0,  0, 0,  0);
        vecs[9]  = mk(1, 0, 1, 3,   12,  4,             1,   1,  1, 2,  5,  0,  0, 0,  0);
        vecs[10] = mk(0, 0, 0, 0,   0,   0,             0,   1,  1, 2,  5,  0,  0, 0,  0);
        vecs[11] = mk(1, 0, 1, 8,   1,   6,             1,   1,  1, 8,  7,  0,  1, 8,  1);
        vecs[12] = mk(0, 0, 0, 0,   0,   0,             1,   1,  0, 0,  0,  0,  0, 0,  0);
        vecs[13] = mk(1, 0, 1, 11,  4,   32'hFFFF_FFFF, 1,   1,  1, 11, 0,  0,  1, 11, 4);
        vecs[14] = mk(0, 0, 0, 0,   0,   0,             1,   1,  0, 0,  0,  0,  0, 0,  0);
        vecs[15] = mk(1, 1, 1, 99,  5,   9,             1,   1,  1, 0,  9,  1,  0, 0,  0);
        vecs[16] = mk(0, 0, 0, 0,   0,   0,             1,   1,  0, 0,  0,  0,  0, 0,  0);

        drive_idle();
        message_ack = 1'b1;
        sys_rst     = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();

        // Reset / idle state.
        check("rst ready",    32'(ready),              32'd1);
        check("rst mvalid",   32'(message_valid),      32'd0);
        check("rst sender",   message_out_sender,      32'd0);
        check("rst level",    message_out_level,       32'd0);
        check("rst barrier",  32'(message_barrier),    32'd0);
        check("rst wr_valid", 32'(state_wr_valid),     32'd0);
        check("rst nodeid",   nodeid_out,              32'd0);
        check("rst parent",   state_out_parent,        32'd0);
        check("rst active",   32'(state_out_active),   32'd0);
        check("rst stat",     stat_sent,               32'd0);

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            valid_in        = vecs[i].v;
            barrier_in      = vecs[i].b;
            state_in_active = vecs[i].a;
            nodeid_in       = vecs[i].nid;
            state_in_parent = vecs[i].par;
            level_in        = vecs[i].lvl;
            message_ack     = vecs[i].ack;
            tick();
            check($sformatf("row%0d ready", i),    32'(ready),            32'(vecs[i].e_rdy));
            check($sformatf("row%0d mvalid", i),   32'(message_valid),    32'(vecs[i].e_mv));
            check($sformatf("row%0d wr_valid", i), 32'(state_wr_valid),   32'(vecs[i].e_wr));
            check($sformatf("row%0d active", i),   32'(state_out_active), 32'd0);
            if (vecs[i].e_mv) begin
                check($sformatf("row%0d sender", i),  message_out_sender,     vecs[i].e_snd);
                check($sformatf("row%0d level", i),   message_out_level,      vecs[i].e_lvl);
                check($sformatf("row%0d barrier", i), 32'(message_barrier),   32'(vecs[i].e_bar));
            end
            if (vecs[i].e_wr) begin
                check($sformatf("row%0d nodeid", i), nodeid_out,       vecs[i].e_nid);
                check($sformatf("row%0d parent", i), state_out_parent, vecs[i].e_par);
            end
        end

        // Nodes 4, 6 then a barrier, with random downstream stalls.
        drive_idle();
        seq_nid = '{32'd4, 32'd6, 32'd55};
        exp_snd = '{32'd4, 32'd6, 32'd0};
        exp_lvl = '{32'd21, 32'd21, 32'd20};
        exp_bar = '{1'b0, 1'b0, 1'b1};
        idx = 0;
        popped = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_snd = '0;
        prev_lvl = '0;
        prev_bar = 1'b0;
        while (popped < 3 && cyc < 200) begin
            message_ack = 1'($urandom_range(0, 1));
            if (idx < 3 && ready) begin
                valid_in        = 1'b1;
                barrier_in      = (idx == 2);
                state_in_active = (idx != 2);
                nodeid_in       = seq_nid[idx];
                state_in_parent = 32'd1;
                level_in        = 32'd20;
            end else begin
                valid_in = 1'b0;
            end
            if (stalled) begin
                check("stall sender",  message_out_sender,    prev_snd);
                check("stall level",   message_out_level,     prev_lvl);
                check("stall barrier", 32'(message_barrier),  32'(prev_bar));
            end
            barrier_left = 1'b0;
            if (message_valid && message_ack) begin
                check($sformatf("seq%0d sender", popped),  message_out_sender,   exp_snd[popped]);
                check($sformatf("seq%0d level", popped),   message_out_level,    exp_lvl[popped]);
                check($sformatf("seq%0d barrier", popped), 32'(message_barrier), 32'(exp_bar[popped]));
`ifdef VBFS_APPLY_STATS_EN
                if (exp_bar[popped]) begin
                    check("stat before barrier", stat_sent, 32'd2);
                    barrier_left = 1'b1;
                end
`endif
                popped++;
            end
            stalled  = message_valid && !message_ack;
            prev_snd = message_out_sender;
            prev_lvl = message_out_level;
            prev_bar = message_barrier;
            if (valid_in && ready) idx++;
            tick();
            cyc++;
            if (barrier_left) begin
                check("stat after barrier", stat_sent, 32'd0);
            end
        end
        check("seq completed", 32'(popped), 32'd3);
        drive_idle();
        message_ack = 1'b1;
        tick();

        // Fill the queue under stall, then reset flushes it.
        message_ack     = 1'b0;
        valid_in        = 1'b1;
        state_in_active = 1'b1;
        level_in        = 32'd3;
        nodeid_in       = 32'd21;
        tick();
        nodeid_in       = 32'd22;
        tick();
        check("full ready",  32'(ready),         32'd0);
        check("full mvalid", 32'(message_valid), 32'd1);
        check("full sender", message_out_sender, 32'd21);
        valid_in = 1'b0;
        sys_rst  = 1'b1;
        tick();
        check("flush mvalid",   32'(message_valid),  32'd0);
        check("flush ready",    32'(ready),          32'd1);
        check("flush wr_valid", 32'(state_wr_valid), 32'd0);
        check("flush stat",     stat_sent,           32'd0);
        // An active node offered while reset is held must not write back.
        valid_in  = 1'b1;
        nodeid_in = 32'd9;
        tick();
        check("rst drop wr_valid", 32'(state_wr_valid), 32'd0);
        check("rst drop mvalid",   32'(message_valid),  32'd0);
        check("rst drop nodeid",   nodeid_out,          32'd0);
        drive_idle();
        sys_rst = 1'b0;
        tick();
        check("post rst ready", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
